// File: rtl/bnn_param_loader_if.sv
// Host-side bundle for the BNN parameter loader: load control, the byte
// stream handshake, the serial chain drive/loopback and the readback port.
interface bnn_param_loader_if;
  logic       start;
  logic       abort;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       setup;
  logic       param_out;
  logic       param_loopback;
  logic       busy;
  logic       done;
  logic [7:0] readback_byte;
  logic       readback_valid;

  modport master (
    output start, abort, byte_in, byte_valid, param_loopback,
    input  byte_ready, setup, param_out, busy, done, readback_byte, readback_valid
  );

  modport slave (
    input  start, abort, byte_in, byte_valid, param_loopback,
    output byte_ready, setup, param_out, busy, done, readback_byte, readback_valid
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Feeds the BNN serial parameter chain: accepts bytes over valid/ready,
// shifts them MSB-first onto param_out with setup high only on cycles that
// carry a real bit, and pulses done after PARAM_BITS bits.
// Optional chain readback is compiled in with BNN_LOADER_READBACK_EN.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | no load active, waiting for start
// WAIT_BYTE | byte_ready high, waiting for the next parameter byte
// SHIFT     | presenting one bit per cycle with setup high
// DONE      | load complete, done pulse visible this cycle
module bnn_param_loader #(
  parameter int PARAM_BITS = 208
) (
  input logic               clk,
  input logic               reset,
  bnn_param_loader_if.slave bus
);
  localparam int CNT_W = $clog2(PARAM_BITS + 1);
  localparam logic [CNT_W-1:0] BITS_MAX = CNT_W'(PARAM_BITS);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] bits_sent;
  logic [7:0]       shreg;
  logic [2:0]       rem;       // bits still to present after the current one
  logic [31:0]      bits_left;
  logic [2:0]       first_rem;

  // Bits of the incoming byte that are still needed; a final partial byte
  // only shifts its top bits, the rest are dropped.
  always_comb begin
    bits_left = 32'(PARAM_BITS) - 32'(bits_sent);
    first_rem = (bits_left >= 32'd8) ? 3'd7 : 3'(bits_left - 32'd1);
  end

  // Load sequencer; all host-visible outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bits_sent      <= '0;
      shreg          <= '0;
      rem            <= '0;
      bus.byte_ready <= 1'b0;
      bus.setup      <= 1'b0;
      bus.param_out  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        // Chain is left partially loaded; host must reload.
        state          <= IDLE;
        bus.byte_ready <= 1'b0;
        bus.setup      <= 1'b0;
        bus.param_out  <= 1'b0;
        bus.busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state          <= WAIT_BYTE;
              bits_sent      <= '0;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
          WAIT_BYTE: begin
            if (bus.byte_valid && bus.byte_ready) begin
              state          <= SHIFT;
              bus.byte_ready <= 1'b0;
              bus.setup      <= 1'b1;
              bus.param_out  <= bus.byte_in[7];
              shreg          <= {bus.byte_in[6:0], 1'b0};
              bits_sent      <= bits_sent + 1'b1;
              rem            <= first_rem;
            end
          end
          SHIFT: begin
            if (rem != 3'd0) begin
              bus.param_out <= shreg[7];
              shreg         <= {shreg[6:0], 1'b0};
              bits_sent     <= bits_sent + 1'b1;
              rem           <= rem - 3'd1;
            end else begin
              bus.setup     <= 1'b0;
              bus.param_out <= 1'b0;
              if (bits_sent == BITS_MAX) begin
                state    <= DONE;
                bus.done <= 1'b1;
              end else begin
                state          <= WAIT_BYTE;
                bus.byte_ready <= 1'b1;
              end
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BNN_LOADER_READBACK_EN
  logic [7:0] cap;
  logic [2:0] cap_idx;
  logic [7:0] cap_next;

  // Place the loopback bit at its MSB-first slot so partial bytes end up
  // left-aligned with zero low bits.
  always_comb begin
    cap_next = cap;
    cap_next[3'd7 - cap_idx] = bus.param_loopback;
  end

  // Capture the chain tail on every shifting cycle and publish per byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap                <= '0;
      cap_idx            <= '0;
      bus.readback_byte  <= '0;
      bus.readback_valid <= 1'b0;
    end else begin
      bus.readback_valid <= 1'b0;
      if (state == SHIFT && !bus.abort) begin
        if (rem == 3'd0) begin
          bus.readback_byte  <= cap_next;
          bus.readback_valid <= 1'b1;
          cap                <= '0;
          cap_idx            <= '0;
        end else begin
          cap     <= cap_next;
          cap_idx <= cap_idx + 3'd1;
        end
      end else if (state != SHIFT) begin
        cap     <= '0;
        cap_idx <= '0;
      end
    end
  end
`else
  // Readback not built: port held at zero.
  assign bus.readback_byte  = '0;
  assign bus.readback_valid = 1'b0;
`endif
endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: a 16-bit and a 12-bit loader side by side,
// expected chain bits queued when each byte is handed over and compared as
// setup-high cycles appear.
module tb_bnn_param_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_param_loader_if bus16();
  bnn_param_loader_if bus12();

  bnn_param_loader #(.PARAM_BITS(16)) u16 (.clk(clk), .reset(reset), .bus(bus16));
  bnn_param_loader #(.PARAM_BITS(12)) u12 (.clk(clk), .reset(reset), .bus(bus12));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_q[$];
  int setup_cnt = 0;
  int done_cnt = 0;
  int rb_cnt = 0;
  bit prev_setup = 1'b0;
  logic m_s, m_p, m_d, m_rv;
  bit m_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops one expected bit per setup-high cycle.
  always @(negedge clk) begin
    m_s  = bus16.setup | bus12.setup;
    m_p  = bus16.setup ? bus16.param_out : bus12.param_out;
    m_d  = bus16.done | bus12.done;
    m_rv = bus16.readback_valid | bus12.readback_valid;
    if (m_s === 1'b1) begin
      setup_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_setup_bit at cycle %0d: param_out=%b, no bit expected", cyc, m_p);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_p !== m_exp) begin
          errors++;
          $display("FAIL param_bit at cycle %0d: got %b expected %b", cyc, m_p, m_exp);
        end
      end
    end
    if (m_d === 1'b1) begin
      done_cnt++;
      checks++;
      if (prev_setup !== 1'b1) begin
        errors++;
        $display("FAIL done_timing at cycle %0d: previous setup %b expected 1", cyc, prev_setup);
      end
    end
    if (m_rv === 1'b1) rb_cnt++;
    prev_setup = (m_s === 1'b1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    exp_q.delete();
    setup_cnt = 0;
    done_cnt = 0;
    rb_cnt = 0;
  endtask

  task automatic do_start(input bit sel);
    if (sel) bus12.start = 1'b1; else bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus12.start = 1'b0;
    checks++;
    if ((sel ? bus12.busy : bus16.busy) !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b expected 1", sel ? bus12.busy : bus16.busy);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int nbits, output int hs_cyc);
    int t = 0;
    hs_cyc = 0;
    while (((sel ? bus12.byte_ready : bus16.byte_ready) !== 1'b1) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 40) begin
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b expected 1 within 40 cycles",
               sel ? bus12.byte_ready : bus16.byte_ready);
    end else begin
      if (sel) begin bus12.byte_in = b; bus12.byte_valid = 1'b1; end
      else begin bus16.byte_in = b; bus16.byte_valid = 1'b1; end
      for (int i = 0; i < nbits; i++) exp_q.push_back(b[7-i]);
      @(posedge clk); #1;
      hs_cyc = cyc;
      bus16.byte_valid = 1'b0;
      bus12.byte_valid = 1'b0;
      checks++;
      if ((sel ? bus12.setup : bus16.setup) !== 1'b1) begin
        errors++;
        $display("FAIL first_bit_latency: setup=%b expected 1", sel ? bus12.setup : bus16.setup);
      end
    end
  endtask

  task automatic wait_idle(input bit sel);
    int t = 0;
    while (((sel ? bus12.busy : bus16.busy) !== 1'b0) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 60) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b expected 0 within 60 cycles", sel ? bus12.busy : bus16.busy);
    end
  endtask

  task automatic check_load(input string name, input int exp_bits, input int exp_done);
    checks++;
    if (setup_cnt != exp_bits) begin
      errors++;
      $display("FAIL %s_setup_count: got %0d expected %0d", name, setup_cnt, exp_bits);
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s_done_count: got %0d expected %0d", name, done_cnt, exp_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_bits_left: got %0d unshifted expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus16.byte_ready, bus16.setup, bus16.param_out, bus16.busy, bus16.done,
         bus16.readback_byte, bus16.readback_valid} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs16: got %b expected all zero",
               {bus16.byte_ready, bus16.setup, bus16.param_out, bus16.busy, bus16.done,
                bus16.readback_byte, bus16.readback_valid});
    end
    checks++;
    if ({bus12.byte_ready, bus12.setup, bus12.busy, bus12.done} !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs12: got %b expected 0000",
               {bus12.byte_ready, bus12.setup, bus12.busy, bus12.done});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int h1, h2;
    clear_mon();
    do_start(1'b0);
    send_byte(1'b0, 8'hA5, 8, h1);
    send_byte(1'b0, 8'h3C, 8, h2);
    checks++;
    if (h2 - h1 != 9) begin
      errors++;
      $display("FAIL byte_spacing: got %0d cycles expected 9", h2 - h1);
    end
    wait_idle(1'b0);
    check_load("b2b", 16, 1);
  endtask

  task automatic test_partial_byte();
    int h, t;
    bit ready_seen;
    clear_mon();
    do_start(1'b1);
    send_byte(1'b1, 8'hFF, 8, h);
    send_byte(1'b1, 8'hF0, 4, h);
    ready_seen = 1'b0;
    t = 0;
    while (bus12.busy !== 1'b0 && t < 40) begin
      if (bus12.byte_ready !== 1'b0) ready_seen = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (ready_seen || t >= 40) begin
      errors++;
      $display("FAIL partial_ready_after_last: ready_seen=%b cycles=%0d expected ready 0 and idle", ready_seen, t);
    end
    check_load("partial", 12, 1);
  endtask

  task automatic test_gap();
    int h;
    bit setup_seen;
    clear_mon();
    do_start(1'b0);
    send_byte(1'b0, 8'hA5, 8, h);
    repeat (8) begin @(posedge clk); #1; end
    setup_seen = 1'b0;
    repeat (5) begin
      if (bus16.setup !== 1'b0) setup_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (setup_seen) begin
      errors++;
      $display("FAIL gap_setup: got setup high during gap expected 0");
    end
    send_byte(1'b0, 8'h3C, 8, h);
    wait_idle(1'b0);
    check_load("gap", 16, 1);
  endtask

  task automatic test_abort();
    int h;
    clear_mon();
    do_start(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    bus16.byte_in = 8'hA5;
    bus16.byte_valid = 1'b1;
    @(posedge clk); #1;
    bus16.byte_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus16.abort = 1'b1;
    @(posedge clk); #1;
    bus16.abort = 1'b0;
    checks++;
    if ({bus16.setup, bus16.busy, bus16.byte_ready} !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs: setup,busy,ready=%b expected 000",
               {bus16.setup, bus16.busy, bus16.byte_ready});
    end
    repeat (5) begin @(posedge clk); #1; end
    check_load("abort", 3, 0);
    clear_mon();
    do_start(1'b0);
    send_byte(1'b0, 8'h5A, 8, h);
    send_byte(1'b0, 8'hC3, 8, h);
    wait_idle(1'b0);
    check_load("reload", 16, 1);
  endtask

  task automatic test_start_with_abort();
    bus16.start = 1'b1;
    bus16.abort = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.abort = 1'b0;
    checks++;
    if ({bus16.busy, bus16.byte_ready} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_idle: busy,ready=%b expected 00", {bus16.busy, bus16.byte_ready});
    end
  endtask

  task automatic test_reset_mid_shift();
    int h;
    clear_mon();
    do_start(1'b0);
    send_byte(1'b0, 8'hA5, 8, h);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus16.setup, bus16.busy, bus16.param_out} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: setup,busy,param_out=%b expected 000",
               {bus16.setup, bus16.busy, bus16.param_out});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_readback();
    int h;
    logic [7:0] rb0, rb1;
    rb0 = 8'h96;
    rb1 = 8'h0F;
    clear_mon();
    do_start(1'b0);
`ifdef BNN_LOADER_READBACK_EN
    send_byte(1'b0, 8'h5A, 8, h);
    for (int i = 0; i < 8; i++) begin
      bus16.param_loopback = rb0[7-i];
      @(posedge clk); #1;
    end
    checks++;
    if (bus16.readback_valid !== 1'b1 || bus16.readback_byte !== rb0) begin
      errors++;
      $display("FAIL readback_first: valid=%b byte=%h expected 1 %h",
               bus16.readback_valid, bus16.readback_byte, rb0);
    end
    send_byte(1'b0, 8'hC3, 8, h);
    for (int i = 0; i < 8; i++) begin
      bus16.param_loopback = rb1[7-i];
      @(posedge clk); #1;
    end
    checks++;
    if (bus16.readback_valid !== 1'b1 || bus16.readback_byte !== rb1) begin
      errors++;
      $display("FAIL readback_second: valid=%b byte=%h expected 1 %h",
               bus16.readback_valid, bus16.readback_byte, rb1);
    end
    bus16.param_loopback = 1'b0;
    wait_idle(1'b0);
    checks++;
    if (rb_cnt != 2) begin
      errors++;
      $display("FAIL readback_pulses: got %0d expected 2", rb_cnt);
    end
`else
    bus16.param_loopback = 1'b1;
    send_byte(1'b0, 8'h5A, 8, h);
    send_byte(1'b0, 8'hC3, 8, h);
    wait_idle(1'b0);
    bus16.param_loopback = 1'b0;
    checks++;
    if (rb_cnt != 0 || bus16.readback_byte !== 8'h00) begin
      errors++;
      $display("FAIL readback_disabled: pulses=%0d byte=%h expected 0 00", rb_cnt, bus16.readback_byte);
    end
`endif
    check_load("readback", 16, 1);
  endtask

  initial begin
    bus16.start = 1'b0; bus16.abort = 1'b0; bus16.byte_in = 8'h00;
    bus16.byte_valid = 1'b0; bus16.param_loopback = 1'b0;
    bus12.start = 1'b0; bus12.abort = 1'b0; bus12.byte_in = 8'h00;
    bus12.byte_valid = 1'b0; bus12.param_loopback = 1'b0;
    reset = 1'b0;
    #2;
    test_reset();
    test_back_to_back();
    test_partial_byte();
    test_gap();
    test_abort();
    test_start_with_abort();
    test_reset_mid_shift();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
